// File: rtl/move_sequencer.sv
// One 2048 move: streams the four lines of the board through a shared merge unit,
// writes each merged line back in place and accumulates the score gain.
module move_sequencer #(
  parameter int unsigned TILE_W  = 4,
  parameter int unsigned SCORE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            dir,
  input  logic [16*TILE_W-1:0]  board_in,
  output logic                  line_req,
  output logic [4*TILE_W-1:0]   line_out,
  input  logic                  line_ack,
  input  logic [4*TILE_W-1:0]   line_in,
  input  logic [SCORE_W-1:0]    line_gain,
  output logic                  busy,
  output logic                  done,
  output logic [16*TILE_W-1:0]  board_out,
  output logic                  moved,
  output logic [SCORE_W-1:0]    gain
);

  localparam int unsigned BOARD_W = 16 * TILE_W;
  localparam int unsigned LINE_W  = 4 * TILE_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

  state_t               state;
  dir_t                 dir_q;
  dir_t                 dir_sel_c;
  logic [1:0]           k_q;
  logic [BOARD_W-1:0]   latch_q;
  logic [BOARD_W-1:0]   work_q;
  logic [SCORE_W-1:0]   acc_q;
  logic [LINE_W-1:0]    line_c;
  logic [BOARD_W-1:0]   scatter_c;
  logic [SCORE_W:0]     sum_c;
  logic [SCORE_W-1:0]   sat_c;
  logic [3:0]           idx;

  // Board cell feeding element j of line k; element 0 is the cell tiles slide toward.
  function automatic logic [3:0] cell_idx(input dir_t d, input logic [1:0] k,
                                          input logic [1:0] j);
    case (d)
      D_LEFT:  cell_idx = {k, j};
      D_RIGHT: cell_idx = {k, ~j};
      D_UP:    cell_idx = {j, k};
      default: cell_idx = {~j, k};
    endcase
  endfunction

  // Lowest set direction bit wins.
  always_comb begin
    if (dir[0])      dir_sel_c = D_LEFT;
    else if (dir[1]) dir_sel_c = D_RIGHT;
    else if (dir[2]) dir_sel_c = D_UP;
    else             dir_sel_c = D_DOWN;
  end

  // Gather line k from the working board and scatter the merged line back.
  always_comb begin
    line_c    = '0;
    scatter_c = work_q;
    idx       = '0;
    for (int j = 0; j < 4; j++) begin
      idx = cell_idx(dir_q, k_q, 2'(j));
      line_c[TILE_W*j +: TILE_W]              = work_q[TILE_W*32'(idx) +: TILE_W];
      scatter_c[TILE_W*32'(idx) +: TILE_W]    = line_in[TILE_W*j +: TILE_W];
    end
  end

  always_comb begin
    sum_c = {1'b0, acc_q} + {1'b0, line_gain};
    sat_c = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      dir_q     <= D_LEFT;
      k_q       <= '0;
      latch_q   <= '0;
      work_q    <= '0;
      acc_q     <= '0;
      line_req  <= 1'b0;
      line_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      board_out <= '0;
      moved     <= 1'b0;
      gain      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (dir != 4'b0000)) begin
            latch_q <= board_in;
            work_q  <= board_in;
            dir_q   <= dir_sel_c;
            acc_q   <= '0;
            k_q     <= '0;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          line_out <= line_c;
          line_req <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (line_ack) begin
            work_q   <= scatter_c;
            acc_q    <= sat_c;
            line_req <= 1'b0;
            if (k_q == 2'd3) begin
              state <= FINISH;
            end else begin
              k_q   <= k_q + 2'd1;
              state <= ISSUE;
            end
          end
        end
        default: begin
          board_out <= work_q;
          moved     <= (work_q != latch_q);
          gain      <= acc_q;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
